// File: rtl/ltlf_trace_sequencer_if.sv
// Stream bundle for the LTLf trace sequencer: symbol input
// and per-trace verdict output, both valid/ready.
interface ltlf_trace_sequencer_if #(
    parameter int NPROP = 2,
    parameter int LEN_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [NPROP-1:0] in_props;
    logic             in_last;
    logic             verdict_valid;
    logic             verdict_ready;
    logic             verdict;
    logic [LEN_W-1:0] verdict_len;

    modport master (
        output in_valid, in_props, in_last, verdict_ready,
        input  in_ready, verdict_valid, verdict, verdict_len
    );

    modport slave (
        input  in_valid, in_props, in_last, verdict_ready,
        output in_ready, verdict_valid, verdict, verdict_len
    );
endinterface

// File: rtl/ltlf_trace_sequencer.sv
// Feeds buffered trace symbols into an LTLf monitor, one per run
// strobe, and returns the monitor's report as a per-trace verdict.
module ltlf_trace_sequencer #(
    parameter int NPROP      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int REPORT_LAT = 2,
    parameter int LEN_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ltlf_trace_sequencer_if.slave  bus,
    output logic [NPROP-1:0]       mon_props,
    output logic                   mon_run,
    output logic                   mon_rst,
    input  logic                   report_in
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(REPORT_LAT + 1);

    typedef enum logic [1:0] {CLEAR, STEP, WAIT, HOLD} state_t;

    typedef struct packed {
        logic             last;
        logic [NPROP-1:0] props;
    } sym_t;

    sym_t             mem [FIFO_DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic             rdy_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             latch;
    logic             take;
    sym_t             head;
    logic [CW-1:0]    cnt;
    logic [LEN_W-1:0] len;
    state_t           state;
    state_t           nxt;

    // Extra pointer bit separates full from empty.
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty = (wp == rp);
    assign head  = mem[rp[AW-1:0]];

    assign bus.in_ready = rdy_q & ~full;
    assign push         = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CLEAR;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            CLEAR: if (rdy_q) nxt = STEP;
            STEP:  if (!empty && head.last) nxt = WAIT;
            WAIT:  if (cnt == CW'(REPORT_LAT)) nxt = HOLD;
            HOLD:  if (bus.verdict_ready) nxt = CLEAR;
            default: nxt = CLEAR;
        endcase
    end

    // rdy_q keeps the monitor reset quiet until rst_n has been released.
    always_comb begin
        mon_rst = (state == CLEAR) && rdy_q;
        pop     = (state == STEP) && !empty;
        latch   = (state == WAIT) && (cnt == CW'(REPORT_LAT));
        take    = (state == HOLD) && bus.verdict_ready;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= {bus.in_last, bus.in_props};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp                <= '0;
            rp                <= '0;
            rdy_q             <= 1'b0;
            mon_props         <= '0;
            mon_run           <= 1'b0;
            cnt               <= '0;
            len               <= '0;
            bus.verdict_valid <= 1'b0;
            bus.verdict       <= 1'b0;
            bus.verdict_len   <= '0;
        end else begin
            rdy_q   <= 1'b1;
            mon_run <= pop;
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                rp        <= rp + 1'b1;
                mon_props <= head.props;
            end
            if (mon_rst)                 len <= '0;
            else if (pop && len != '1)   len <= len + 1'b1;
            // Report latency is counted from the final run pulse.
            if (pop)                     cnt <= '0;
            else if (state == WAIT)      cnt <= cnt + 1'b1;
            if (latch) begin
                bus.verdict_valid <= 1'b1;
                bus.verdict       <= report_in;
                bus.verdict_len   <= len;
            end else if (take) begin
                bus.verdict_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ltlf_trace_sequencer.sv
// Directed bench for ltlf_trace_sequencer driving a G(A -> F B)
// monitor model; second instance checks length saturation.
module tb_ltlf_trace_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ltlf_trace_sequencer_if #(.NPROP(2), .LEN_W(16)) ifa ();
    ltlf_trace_sequencer_if #(.NPROP(2), .LEN_W(3))  ifb ();

    logic [1:0] ma_props;
    logic [1:0] mb_props;
    logic       ma_run, ma_rst, mb_run, mb_rst;
    logic       pa = 1'b0;
    logic       pb = 1'b0;
    logic       ra, rb;
    assign ra = ~pa;
    assign rb = ~pb;

    ltlf_trace_sequencer #(
        .NPROP(2), .FIFO_DEPTH(4), .REPORT_LAT(2), .LEN_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave),
        .mon_props(ma_props), .mon_run(ma_run),
        .mon_rst(ma_rst), .report_in(ra)
    );

    ltlf_trace_sequencer #(
        .NPROP(2), .FIFO_DEPTH(4), .REPORT_LAT(2), .LEN_W(3)
    ) dut6 (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave),
        .mon_props(mb_props), .mon_run(mb_run),
        .mon_rst(mb_rst), .report_in(rb)
    );

    // Monitor: pending = an A is still waiting for a B.
    always @(posedge clk) begin
        if (ma_rst)      pa <= 1'b0;
        else if (ma_run) pa <= ma_props[1] ? 1'b0 : (pa | ma_props[0]);
        if (mb_rst)      pb <= 1'b0;
        else if (mb_run) pb <= mb_props[1] ? 1'b0 : (pb | mb_props[0]);
    end

    int         runs_a = 0;
    int         rsts_a = 0;
    int         runs_b = 0;
    int         log_n = 0;
    logic [1:0] log_p [32];
    logic       overlap = 1'b0;

    always @(negedge clk) begin
        if (ma_run) begin
            runs_a++;
            if (log_n < 32) begin
                log_p[log_n] = ma_props;
                log_n++;
            end
        end
        if (ma_rst) rsts_a++;
        if (mb_run) runs_b++;
        if ((ma_run && ma_rst) || (mb_run && mb_rst)) overlap = 1'b1;
    end

    int tests = 0;
    int fails = 0;
    int snap_run = 0;
    int snap_rst = 0;

    localparam logic [1:0] TBL [6] = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b10};

    task automatic send(input logic [1:0] p, input logic l);
        int n;
        n = 0;
        ifa.in_valid = 1'b1;
        ifa.in_props = p;
        ifa.in_last  = l;
        while (!ifa.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL send_timeout: in_ready=%0b want 1", ifa.in_ready);
        end
        @(negedge clk);
        ifa.in_valid = 1'b0;
    endtask

    task automatic wait_verdict(input logic ev, input logic [15:0] el, input string nm);
        int n;
        n = 0;
        while (!ifa.verdict_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        snap_run = runs_a;
        snap_rst = rsts_a;
        tests++;
        if (!ifa.verdict_valid) begin
            fails++;
            $display("FAIL %s_timeout: verdict_valid=0 want 1", nm);
        end else begin
            tests++;
            if (ifa.verdict !== ev) begin
                fails++;
                $display("FAIL %s_verdict: got %0b want %0b", nm, ifa.verdict, ev);
            end
            tests++;
            if (ifa.verdict_len !== el) begin
                fails++;
                $display("FAIL %s_len: got %0d want %0d", nm, ifa.verdict_len, el);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        ifa.in_valid = 0; ifa.in_props = 0; ifa.in_last = 0; ifa.verdict_ready = 1;
        ifb.in_valid = 0; ifb.in_props = 0; ifb.in_last = 0; ifb.verdict_ready = 1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (ifa.in_ready !== 1'b0 || ma_run !== 1'b0 || ma_rst !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl: rdy=%0b run=%0b rst=%0b want 0", ifa.in_ready, ma_run, ma_rst);
        end
        tests++;
        if (ma_props !== 2'b00 || ifa.verdict_valid !== 1'b0 ||
            ifa.verdict !== 1'b0 || ifa.verdict_len !== 16'd0) begin
            fails++;
            $display("FAIL reset_data: props=%0d vv=%0b v=%0b len=%0d want 0",
                     ma_props, ifa.verdict_valid, ifa.verdict, ifa.verdict_len);
        end
        snap_run = runs_a;
        snap_rst = rsts_a;
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (ifa.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL release_ready: got %0b want 1", ifa.in_ready);
        end
        tests++;
        if (ma_rst !== 1'b1) begin
            fails++;
            $display("FAIL release_monrst: got %0b want 1", ma_rst);
        end
        @(negedge clk);
        tests++;
        if (ma_rst !== 1'b0) begin
            fails++;
            $display("FAIL monrst_one_cycle: got %0b want 0", ma_rst);
        end
    endtask

    task automatic test_basic_trace();
        int r0, s0;
        r0 = snap_run;
        s0 = snap_rst;
        send(2'b01, 1'b0);
        send(2'b00, 1'b0);
        send(2'b10, 1'b1);
        wait_verdict(1'b1, 16'd3, "t1");
        tests++;
        if (snap_run - r0 != 3) begin
            fails++;
            $display("FAIL t1_runs: got %0d want 3", snap_run - r0);
        end
        tests++;
        if (snap_rst - s0 != 1) begin
            fails++;
            $display("FAIL t1_rsts: got %0d want 1", snap_rst - s0);
        end
    endtask

    task automatic test_back_to_back();
        int s1;
        send(2'b01, 1'b1);
        wait_verdict(1'b0, 16'd1, "t2a");
        s1 = snap_rst;
        send(2'b00, 1'b1);
        wait_verdict(1'b1, 16'd1, "t2b");
        tests++;
        if (snap_rst - s1 != 1) begin
            fails++;
            $display("FAIL t2_rst_between: got %0d want 1", snap_rst - s1);
        end
    endtask

    task automatic test_fifo_full();
        int acc, base;
        logic ok;
        ifa.verdict_ready = 1'b0;
        send(2'b10, 1'b1);
        wait_verdict(1'b1, 16'd1, "t3a");
        base = log_n;
        acc = 0;
        ifa.in_valid = 1'b1;
        ifa.in_props = TBL[0];
        ifa.in_last  = 1'b0;
        for (int c = 0; c < 8; c++) begin
            ok = ifa.in_ready;
            @(negedge clk);
            if (ok) begin
                acc++;
                ifa.in_props = TBL[acc % 6];
                ifa.in_last  = (acc == 5);
            end
        end
        tests++;
        if (acc != 4) begin
            fails++;
            $display("FAIL t3_accept_full: got %0d want 4", acc);
        end
        tests++;
        if (ifa.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL t3_ready_full: got %0b want 0", ifa.in_ready);
        end
        ifa.verdict_ready = 1'b1;
        for (int c = 0; c < 30 && acc < 6; c++) begin
            ok = ifa.in_ready;
            @(negedge clk);
            if (ok) begin
                acc++;
                if (acc < 6) begin
                    ifa.in_props = TBL[acc];
                    ifa.in_last  = (acc == 5);
                end else begin
                    ifa.in_valid = 1'b0;
                end
            end
        end
        ifa.in_valid = 1'b0;
        tests++;
        if (acc != 6) begin
            fails++;
            $display("FAIL t3_accept_all: got %0d want 6", acc);
        end
        wait_verdict(1'b1, 16'd6, "t3b");
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (log_p[base+i] !== TBL[i]) begin
                fails++;
                $display("FAIL t3_order[%0d]: got %0d want %0d", i, log_p[base+i], TBL[i]);
            end
        end
    endtask

    task automatic test_stall();
        send(2'b01, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (ma_run !== 1'b0 || ma_props !== 2'b01) begin
                fails++;
                $display("FAIL t4_gap[%0d]: run=%0b props=%0d want 0/1", i, ma_run, ma_props);
            end
        end
        send(2'b10, 1'b1);
        wait_verdict(1'b1, 16'd2, "t4");
    endtask

    task automatic test_reset_mid_trace();
        int n, s0;
        send(2'b01, 1'b1);
        n = 0;
        while (!ma_run && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!ma_run) begin
            fails++;
            $display("FAIL t5_run_seen: got 0 want 1");
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (ma_props !== 2'b00 || ma_run !== 1'b0 || ma_rst !== 1'b0 ||
            ifa.in_ready !== 1'b0 || ifa.verdict_valid !== 1'b0) begin
            fails++;
            $display("FAIL t5_async_clear: props=%0d run=%0b rst=%0b rdy=%0b vv=%0b want 0",
                     ma_props, ma_run, ma_rst, ifa.in_ready, ifa.verdict_valid);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (ifa.verdict_valid !== 1'b0) begin
            fails++;
            $display("FAIL t5_no_verdict: got %0b want 0", ifa.verdict_valid);
        end
        s0 = rsts_a;
        rst_n = 1'b1;
        @(negedge clk);
        send(2'b10, 1'b1);
        wait_verdict(1'b1, 16'd1, "t5");
        tests++;
        if (snap_rst - s0 != 1) begin
            fails++;
            $display("FAIL t5_rst_pulse: got %0d want 1", snap_rst - s0);
        end
    endtask

    task automatic test_saturation();
        int n, tmo;
        tmo = 0;
        for (int i = 0; i < 10; i++) begin
            ifb.in_valid = 1'b1;
            ifb.in_props = 2'b00;
            ifb.in_last  = (i == 9);
            n = 0;
            while (!ifb.in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) tmo++;
            @(negedge clk);
            ifb.in_valid = 1'b0;
        end
        n = 0;
        while (!ifb.verdict_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (tmo != 0 || !ifb.verdict_valid) begin
            fails++;
            $display("FAIL t6_timeout: tmo=%0d vv=%0b want 0/1", tmo, ifb.verdict_valid);
        end
        tests++;
        if (ifb.verdict_len !== 3'd7) begin
            fails++;
            $display("FAIL t6_len_sat: got %0d want 7", ifb.verdict_len);
        end
        tests++;
        if (ifb.verdict !== 1'b1) begin
            fails++;
            $display("FAIL t6_verdict: got %0b want 1", ifb.verdict);
        end
        tests++;
        if (runs_b != 10) begin
            fails++;
            $display("FAIL t6_runs: got %0d want 10", runs_b);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_trace();
        test_back_to_back();
        test_fifo_full();
        test_stall();
        test_reset_mid_trace();
        test_saturation();
        tests++;
        if (overlap !== 1'b0) begin
            fails++;
            $display("FAIL run_rst_overlap: got %0b want 0", overlap);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
